// File: rtl/tmds_gearbox_ctrl.sv
// -----------------------------------------------------------------------------
// tmds_gearbox_ctrl
//
// Feeds one TMDS lane into a 4:1 OSERDESE3 (DATA_WIDTH=4). Each 10-bit symbol
// arrives over a valid/ready handshake. The block emits one 4-bit D word per
// clk, so every 5 clks carry 2 symbols (10:4 gearbox). The block also holds the
// OSERDES in reset for RST_CYCLES clks after rst is released. When the source
// has no symbol ready, the block substitutes IDLE_SYM.
//
// Optional build macro: TMDS_GEARBOX_STATS_EN
//   defined   -> 16-bit saturating count of inserted idle symbols
//   undefined -> o_underflow_cnt is tied to zero
//
// Ports
//   clk             in   OSERDES CLKDIV-domain clock, posedge logic
//   rst             in   synchronous active-high reset
//   s_sym[9:0]      in   TMDS symbol, bit0 is transmitted first
//   s_valid         in   s_sym is valid
//   s_ready         out  s_sym is consumed this cycle when s_valid & s_ready
//   o_serdes_d[3:0] out  OSERDESE3 D[3:0], D[0] is serialized first
//   o_serdes_rst    out  OSERDESE3 RST
//   o_streaming     out  high while the FSM is in S_RUN
//   o_underflow     out  1-cycle pulse when an idle symbol was inserted
//   o_underflow_cnt out  saturating count of inserted idle symbols
// -----------------------------------------------------------------------------
module tmds_gearbox_ctrl #(
  parameter int unsigned RST_CYCLES = 8,
  parameter logic [9:0]  IDLE_SYM   = 10'b1101010100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  s_sym,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [3:0]  o_serdes_d,
  output logic        o_serdes_rst,
  output logic        o_streaming,
  output logic        o_underflow,
  output logic [15:0] o_underflow_cnt
);

  localparam int unsigned HCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_CYCLES - 1);

  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e         state_q;
  logic [HCW-1:0] hold_cnt_q;
  logic [13:0]    buf_q;
  logic [3:0]     bcnt_q;
  logic [3:0]     serdes_d_q;
  logic           serdes_rst_q;
  logic           streaming_q;
  logic           underflow_q;

  logic           ready_d;
  logic [9:0]     sym_d;
  logic [13:0]    merged_d;

  // Gearbox datapath: pick the symbol and merge it above the bits still buffered.
  always_comb begin
    ready_d  = (state_q == S_RUN) && (bcnt_q < 4'd4);
    sym_d    = s_valid ? s_sym : IDLE_SYM;
    // bcnt is at most 2 when a symbol is merged, so the result fits in 12 bits.
    merged_d = buf_q | (14'(sym_d) << bcnt_q);
  end

  assign s_ready = ready_d;

  // Reset-hold sequencer, gearbox state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      buf_q        <= 14'd0;
      bcnt_q       <= 4'd0;
      serdes_d_q   <= 4'd0;
      serdes_rst_q <= 1'b1;
      streaming_q  <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          serdes_d_q  <= 4'd0;
          underflow_q <= 1'b0;
          buf_q       <= 14'd0;
          bcnt_q      <= 4'd0;
          if (hold_cnt_q == HOLD_LAST) begin
            // OSERDES leaves reset on the same edge streaming starts.
            state_q      <= S_RUN;
            serdes_rst_q <= 1'b0;
            streaming_q  <= 1'b1;
          end else begin
            hold_cnt_q   <= hold_cnt_q + HCW'(1);
            serdes_rst_q <= 1'b1;
            streaming_q  <= 1'b0;
          end
        end
        S_RUN: begin
          serdes_rst_q <= 1'b0;
          streaming_q  <= 1'b1;
          if (ready_d) begin
            serdes_d_q  <= merged_d[3:0];
            buf_q       <= merged_d >> 4;
            bcnt_q      <= bcnt_q + 4'd6;
            underflow_q <= !s_valid;
          end else begin
            serdes_d_q  <= buf_q[3:0];
            buf_q       <= buf_q >> 4;
            bcnt_q      <= bcnt_q - 4'd4;
            underflow_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_HOLD;
          hold_cnt_q   <= '0;
          buf_q        <= 14'd0;
          bcnt_q       <= 4'd0;
          serdes_d_q   <= 4'd0;
          serdes_rst_q <= 1'b1;
          streaming_q  <= 1'b0;
          underflow_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TMDS_GEARBOX_STATS_EN
  logic [15:0] underflow_cnt_q;

  // Saturating count of idle symbols inserted on underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_cnt_q <= 16'd0;
    end else if (ready_d && !s_valid && (underflow_cnt_q != 16'hFFFF)) begin
      underflow_cnt_q <= underflow_cnt_q + 16'd1;
    end else begin
      underflow_cnt_q <= underflow_cnt_q;
    end
  end

  assign o_underflow_cnt = underflow_cnt_q;
`else
  assign o_underflow_cnt = 16'd0;
`endif

  assign o_serdes_d   = serdes_d_q;
  assign o_serdes_rst = serdes_rst_q;
  assign o_streaming  = streaming_q;
  assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_tmds_gearbox_ctrl.sv
// Directed testbench for tmds_gearbox_ctrl (default parameters).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_tmds_gearbox_ctrl;

  logic        clk;
  logic        rst;
  logic [9:0]  s_sym;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  o_serdes_d;
  logic        o_serdes_rst;
  logic        o_streaming;
  logic        o_underflow;
  logic [15:0] o_underflow_cnt;

  int errors = 0;
  int checks = 0;

`ifdef TMDS_GEARBOX_STATS_EN
  localparam logic [15:0] CNT_AFTER_5 = 16'd2;
`else
  localparam logic [15:0] CNT_AFTER_5 = 16'd0;
`endif

  tmds_gearbox_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .s_sym          (s_sym),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .o_serdes_d     (o_serdes_d),
    .o_serdes_rst   (o_serdes_rst),
    .o_streaming    (o_streaming),
    .o_underflow    (o_underflow),
    .o_underflow_cnt(o_underflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then wait out the 8-cycle hold so the block sits at the first S_RUN cycle.
  task automatic go_run();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_sym = 10'd0;
    repeat (5) step();
    checks++;
    if (o_serdes_d !== 4'd0 || o_serdes_rst !== 1'b1 || s_ready !== 1'b0 ||
        o_streaming !== 1'b0 || o_underflow !== 1'b0 || o_underflow_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: d=%h srst=%b rdy=%b strm=%b uf=%b cnt=%h, need 0,1,0,0,0,0",
               o_serdes_d, o_serdes_rst, s_ready, o_streaming, o_underflow, o_underflow_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o_serdes_rst !== 1'b1 || o_streaming !== 1'b0 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: srst=%b strm=%b rdy=%b, need 1,0,0",
                 i, o_serdes_rst, o_streaming, s_ready);
      end
      step();
    end
    checks++;
    if (o_serdes_rst !== 1'b0 || o_streaming !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: srst=%b strm=%b rdy=%b, need 0,1,1",
               o_serdes_rst, o_streaming, s_ready);
    end
  endtask

  task automatic test_gearbox_order();
    logic [3:0] exp_d [5];
    logic       exp_r [5];
    int         nacc;
    exp_d[0] = 4'h0; exp_d[1] = 4'hE; exp_d[2] = 4'hF; exp_d[3] = 4'h7; exp_d[4] = 4'h0;
    exp_r[0] = 1'b1; exp_r[1] = 1'b0; exp_r[2] = 1'b1; exp_r[3] = 1'b0; exp_r[4] = 1'b0;
    go_run();
    s_valid = 1'b1;
    s_sym   = 10'h3E0;
    nacc    = 0;
    for (int k = 0; k < 5; k++) begin
      logic was_ready;
      was_ready = s_ready;
      checks++;
      if (was_ready !== exp_r[k]) begin
        errors++;
        $display("FAIL gear_ready word %0d: got %b need %b", k + 1, was_ready, exp_r[k]);
      end
      step();
      if (was_ready === 1'b1) begin
        nacc++;
        s_sym = (nacc == 1) ? 10'h01F : 10'h000;
      end
      checks++;
      if (o_serdes_d !== exp_d[k]) begin
        errors++;
        $display("FAIL gear_word %0d: got %h need %h", k + 1, o_serdes_d, exp_d[k]);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_sustained_rate();
    logic [9:0] syms  [1000];
    logic [3:0] words [2500];
    int idx, win_acc, bad_win, bad_sym, uf_seen;
    for (int i = 0; i < 1000; i++) syms[i] = 10'($urandom_range(0, 1023));
    go_run();
    idx = 0; win_acc = 0; bad_win = 0; bad_sym = 0; uf_seen = 0;
    for (int c = 0; c < 2500; c++) begin
      logic acc;
      s_valid = (idx < 1000);
      s_sym   = (idx < 1000) ? syms[idx] : 10'd0;
      acc     = s_ready & s_valid;
      step();
      if (acc) begin
        idx++;
        win_acc++;
      end
      words[c] = o_serdes_d;
      if (o_underflow !== 1'b0) uf_seen++;
      if ((c % 5) == 4) begin
        if (win_acc != 2) bad_win++;
        win_acc = 0;
      end
    end
    s_valid = 1'b0;
    for (int j = 0; j < 1000; j++) begin
      logic [9:0] got;
      for (int b = 0; b < 10; b++) got[b] = words[(10 * j + b) / 4][(10 * j + b) % 4];
      if (got !== syms[j]) bad_sym++;
    end
    checks++;
    if (idx != 1000) begin
      errors++;
      $display("FAIL rate_total: accepted %0d need 1000", idx);
    end
    checks++;
    if (bad_win != 0) begin
      errors++;
      $display("FAIL rate_window: %0d windows without 2 accepts, need 0", bad_win);
    end
    checks++;
    if (bad_sym != 0) begin
      errors++;
      $display("FAIL rate_stream: %0d symbols differ, need 0", bad_sym);
    end
    checks++;
    if (uf_seen != 0) begin
      errors++;
      $display("FAIL rate_underflow: %0d pulses, need 0", uf_seen);
    end
  endtask

  // Idle symbol 0x354 serialized LSB-first gives words 4,5,3,5,D per two symbols.
  task automatic test_underflow();
    logic [3:0] exp_d  [5];
    logic       exp_uf [5];
    exp_d[0] = 4'h4; exp_d[1] = 4'h5; exp_d[2] = 4'h3; exp_d[3] = 4'h5; exp_d[4] = 4'hD;
    exp_uf[0] = 1'b1; exp_uf[1] = 1'b0; exp_uf[2] = 1'b1; exp_uf[3] = 1'b0; exp_uf[4] = 1'b0;
    go_run();
    s_valid = 1'b0;
    s_sym   = 10'h0AA;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (o_serdes_d !== exp_d[k % 5] || o_underflow !== exp_uf[k % 5]) begin
        errors++;
        $display("FAIL idle_word %0d: d=%h uf=%b need d=%h uf=%b",
                 k, o_serdes_d, o_underflow, exp_d[k % 5], exp_uf[k % 5]);
      end
      if (k == 4) begin
        checks++;
        if (o_underflow_cnt !== CNT_AFTER_5) begin
          errors++;
          $display("FAIL idle_cnt: got %0d need %0d", o_underflow_cnt, CNT_AFTER_5);
        end
      end
    end
  endtask

`ifdef TMDS_GEARBOX_STATS_EN
  task automatic test_saturation();
    go_run();
    s_valid = 1'b0;
    force dut.underflow_cnt_q = 16'hFFFE;
    release dut.underflow_cnt_q;
    step();
    checks++;
    if (o_underflow_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: got %h need FFFF", o_underflow_cnt);
    end
    repeat (10) step();
    checks++;
    if (o_underflow_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h need FFFF", o_underflow_cnt);
    end
  endtask
`endif

  task automatic test_mid_reset();
    go_run();
    s_valid = 1'b1;
    s_sym   = 10'h3E0;
    step();
    s_sym = 10'h01F;
    checks++;
    if (s_ready !== 1'b0 || o_serdes_d !== 4'h0) begin
      errors++;
      $display("FAIL mid_pre: rdy=%b d=%h need 0,0", s_ready, o_serdes_d);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (o_serdes_rst !== 1'b1 || o_serdes_d !== 4'h0 || s_ready !== 1'b0 || o_streaming !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: srst=%b d=%h rdy=%b strm=%b need 1,0,0,0",
               o_serdes_rst, o_serdes_d, s_ready, o_streaming);
    end
    repeat (7) step();
    checks++;
    if (o_serdes_rst !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold: srst=%b rdy=%b need 1,0", o_serdes_rst, s_ready);
    end
    step();
    checks++;
    if (o_serdes_rst !== 1'b0 || o_streaming !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart: srst=%b strm=%b rdy=%b need 0,1,1",
               o_serdes_rst, o_streaming, s_ready);
    end
    s_sym = 10'h3E0;
    step();
    checks++;
    if (o_serdes_d !== 4'h0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_word1: d=%h rdy=%b need 0,0", o_serdes_d, s_ready);
    end
    step();
    checks++;
    if (o_serdes_d !== 4'hE || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_word2: d=%h rdy=%b need E,1", o_serdes_d, s_ready);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_sym = 10'd0;
    test_reset();
    test_gearbox_order();
    test_sustained_rate();
    test_underflow();
`ifdef TMDS_GEARBOX_STATS_EN
    test_saturation();
`endif
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
